// File: rtl/trap_ctrl_pkg.sv
// Shared cause codes, CSR bit positions, FSM encoding and mstatus/target helpers
// for the machine-mode trap sequencer.
package trap_ctrl_pkg;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;

  localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER   = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_COMMIT    = 2'd2,
    S_REDIRECT  = 2'd3
  } state_t;

  typedef enum logic {
    K_TRAP = 1'b0,
    K_MRET = 1'b1
  } kind_t;

  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MPP_HI:MPP_LO] = 2'b11;
    r[MPIE_BIT]      = m[MIE_BIT];
    r[MIE_BIT]       = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MIE_BIT]       = m[MPIE_BIT];
    r[MPIE_BIT]      = 1'b1;
    r[MPP_HI:MPP_LO] = 2'b11;
    return r;
  endfunction

  // Vectoring applies only to interrupt causes; exceptions always use the base.
  function automatic logic [31:0] redirect_target(input kind_t k, input logic [31:0] cause,
                                                  input logic [31:0] mepc, input logic [31:0] mtvec,
                                                  input logic vec_en);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (k == K_MRET) return mepc;
    if (vec_en && mtvec[1:0] == 2'b01 && cause[31]) return base + {25'd0, cause[4:0], 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchroniser bringing the asynchronous external interrupt into clk.
module trap_ctrl_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: latches an EX event, strobes the CSR
// update port once, then redirects the pipeline to the trap vector or mepc.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int VECTORED_EN     = 1,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_ecall,
  input  logic        ex_ebreak,
  input  logic        ex_illegal,
  input  logic        ex_mret,
  input  logic        ex_busy,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mepc,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mie,
  output logic        trap_mepc_vld,
  output logic        trap_mcause_vld,
  output logic        trap_mstatus_vld,
  output logic [31:0] trap_mepc,
  output logic [31:0] trap_mcause,
  output logic [31:0] trap_mstatus,
  output logic        hold,
  output logic        flush,
  output logic        redirect_vld,
  output logic [31:0] redirect_pc,
  output logic [31:0] irq_pending
);

  logic irq_ext_s;

  trap_ctrl_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_ext),
    .q   (irq_ext_s)
  );

  state_t      state;
  kind_t       kind;
  logic [31:0] cause_q;
  logic [31:0] pc_q;

  logic        int_ext, int_tmr, int_take, exc, event_now, go_commit;
  kind_t       ev_kind, cm_kind;
  logic [31:0] ev_cause, cm_cause, cm_pc;

  assign int_ext   = irq_ext_s & csr_mie[MEIP_BIT];
  assign int_tmr   = irq_timer & csr_mie[MTIP_BIT];
  assign int_take  = csr_mstatus[MIE_BIT] & ex_valid & (int_ext | int_tmr);
  assign exc       = ex_valid & (ex_ecall | ex_ebreak | ex_illegal | ex_mret);
  assign event_now = ~rst & (state == S_IDLE) & (int_take | exc);

  always_comb begin
    ev_kind  = K_TRAP;
    ev_cause = CAUSE_ECALL;
    if (int_take)        ev_cause = int_ext ? CAUSE_EXT : CAUSE_TIMER;
    else if (ex_illegal) ev_cause = CAUSE_ILLEGAL;
    else if (ex_ebreak)  ev_cause = CAUSE_EBREAK;
    else if (ex_ecall)   ev_cause = CAUSE_ECALL;
    else begin
      ev_kind  = K_MRET;
      ev_cause = '0;
    end
  end

  // Entering COMMIT straight from IDLE uses the live event, otherwise the latched one.
  assign cm_kind   = (state == S_IDLE) ? ev_kind  : kind;
  assign cm_cause  = (state == S_IDLE) ? ev_cause : cause_q;
  assign cm_pc     = (state == S_IDLE) ? ex_pc    : pc_q;
  assign go_commit = ~ex_busy & (event_now | (state == S_WAIT_BUSY));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      kind             <= K_TRAP;
      cause_q          <= '0;
      pc_q             <= '0;
      trap_mepc_vld    <= 1'b0;
      trap_mcause_vld  <= 1'b0;
      trap_mstatus_vld <= 1'b0;
      trap_mepc        <= '0;
      trap_mcause      <= '0;
      trap_mstatus     <= '0;
      redirect_vld     <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      trap_mepc_vld    <= 1'b0;
      trap_mcause_vld  <= 1'b0;
      trap_mstatus_vld <= 1'b0;
      redirect_vld     <= 1'b0;
      case (state)
        S_IDLE: if (event_now) begin
          kind    <= ev_kind;
          cause_q <= ev_cause;
          pc_q    <= ex_pc;
          state   <= ex_busy ? S_WAIT_BUSY : S_COMMIT;
        end
        S_WAIT_BUSY: if (!ex_busy) state <= S_COMMIT;
        S_COMMIT: begin
          state        <= S_REDIRECT;
          redirect_vld <= 1'b1;
          redirect_pc  <= redirect_target(kind, cause_q, csr_mepc, csr_mtvec, VECTORED_EN != 0);
        end
        default: state <= S_IDLE;
      endcase
      if (go_commit) begin
        trap_mepc_vld    <= (cm_kind == K_TRAP);
        trap_mcause_vld  <= (cm_kind == K_TRAP);
        trap_mstatus_vld <= 1'b1;
        trap_mepc        <= cm_pc;
        trap_mcause      <= cm_cause;
        trap_mstatus     <= (cm_kind == K_TRAP) ? mstatus_on_trap(csr_mstatus)
                                                : mstatus_on_mret(csr_mstatus);
      end
    end
  end

  assign hold  = (state != S_IDLE) | event_now;
  assign flush = hold;

  always_comb begin
    irq_pending           = '0;
    irq_pending[MEIP_BIT] = irq_ext_s;
    irq_pending[MTIP_BIT] = irq_timer;
  end

  logic unused_mie;
  assign unused_mie = ^{csr_mie[31:12], csr_mie[10:8], csr_mie[6:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed plus randomized checks of trap_ctrl against an arithmetic reference model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_ecall, ex_ebreak, ex_illegal, ex_mret, ex_busy;
  logic        irq_ext, irq_timer;
  logic [31:0] csr_mstatus, csr_mepc, csr_mtvec, csr_mie;
  logic        trap_mepc_vld, trap_mcause_vld, trap_mstatus_vld;
  logic [31:0] trap_mepc, trap_mcause, trap_mstatus;
  logic        hold, flush, redirect_vld;
  logic [31:0] redirect_pc, irq_pending;

  int total  = 0;
  int passed = 0;

  trap_ctrl #(.VECTORED_EN(1), .IRQ_SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_ecall(ex_ecall), .ex_ebreak(ex_ebreak), .ex_illegal(ex_illegal), .ex_mret(ex_mret),
    .ex_busy(ex_busy), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .csr_mstatus(csr_mstatus), .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec), .csr_mie(csr_mie),
    .trap_mepc_vld(trap_mepc_vld), .trap_mcause_vld(trap_mcause_vld),
    .trap_mstatus_vld(trap_mstatus_vld), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
    .trap_mstatus(trap_mstatus), .hold(hold), .flush(flush), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/strobes"}, {29'd0, trap_mepc_vld, trap_mcause_vld, trap_mstatus_vld}, 32'd0);
    chk({tag, "/redir"}, {31'd0, redirect_vld}, 32'd0);
  endtask

  task automatic set_class(input logic [3:0] cls);
    {ex_mret, ex_illegal, ex_ebreak, ex_ecall} = cls;
  endtask

  // cls = {mret, illegal, ebreak, ecall}; ext_late raises irq_ext only in the event cycle.
  task automatic run_event(input string tag, input logic [3:0] cls, input logic [31:0] pc,
                           input logic [31:0] ms, input logic [31:0] mepc, input logic [31:0] mtvec,
                           input logic [31:0] mie, input logic ext, input logic timer,
                           input logic ext_late, input int busy);
    logic        ext_seen, irq_on, has_ev, is_trap;
    logic [31:0] cause, exp_ms, target;
    ext_seen = ext & ~ext_late;
    ex_valid = 1'b0; set_class(4'd0); ex_busy = 1'b0; ex_pc = pc;
    csr_mstatus = ms; csr_mepc = mepc; csr_mtvec = mtvec; csr_mie = mie;
    irq_ext = ext_seen; irq_timer = timer;
    repeat (4) tick();
    chk({tag, "/idle_hold"}, {31'd0, hold}, 32'd0);
    chk({tag, "/mip"}, irq_pending, (ext_seen ? 32'h800 : 32'h0) | (timer ? 32'h80 : 32'h0));

    // reference model
    irq_on  = ms[3] && ((ext_seen && mie[11]) || (timer && mie[7]));
    has_ev  = 1'b1; is_trap = 1'b1; cause = 32'd0;
    if (irq_on)      cause = (ext_seen && mie[11]) ? 32'h8000000B : 32'h80000007;
    else if (cls[2]) cause = 2;
    else if (cls[1]) cause = 3;
    else if (cls[0]) cause = 11;
    else if (cls[3]) is_trap = 1'b0;
    else             has_ev = 1'b0;
    if (is_trap) exp_ms = (ms & ~32'h1888) | 32'h1800 | (((ms >> 3) & 1) << 7);
    else         exp_ms = (ms & ~32'h0088) | 32'h1880 | (((ms >> 7) & 1) << 3);
    if (!is_trap) target = mepc;
    else begin
      target = mtvec & ~32'h3;
      if ((mtvec % 4) == 1 && cause >= 32'h80000000) target = target + 4 * (cause % 32);
    end

    ex_valid = 1'b1; set_class(cls); ex_busy = (busy > 0);
    if (ext_late) irq_ext = 1'b1;
    #1;
    chk({tag, "/n_hold"}, {30'd0, hold, flush}, has_ev ? 32'd3 : 32'd0);
    if (!has_ev) begin
      tick();
      ex_valid = 1'b0; set_class(4'd0);
      repeat (2) begin
        chk_quiet({tag, "/none"});
        chk({tag, "/none_hold"}, {31'd0, hold}, 32'd0);
        tick();
      end
      return;
    end
    for (int i = 1; i <= busy; i++) begin
      tick();
      ex_valid = 1'b0; set_class(4'd0);
      if (i == busy) ex_busy = 1'b0;
      #1;
      chk({tag, "/wait_hold"}, {30'd0, hold, flush}, 32'd3);
      chk_quiet({tag, "/wait"});
    end
    tick();
    ex_valid = 1'b0; set_class(4'd0); ex_busy = 1'b0;
    chk({tag, "/c_vld"}, {29'd0, trap_mepc_vld, trap_mcause_vld, trap_mstatus_vld},
        is_trap ? 32'd7 : 32'd1);
    chk({tag, "/c_ms"}, trap_mstatus, exp_ms);
    if (is_trap) begin
      chk({tag, "/c_mepc"}, trap_mepc, pc);
      chk({tag, "/c_cause"}, trap_mcause, cause);
    end
    chk({tag, "/c_hold"}, {30'd0, hold, flush}, 32'd3);
    chk({tag, "/c_redir"}, {31'd0, redirect_vld}, 32'd0);
    tick();
    chk({tag, "/r_vld"}, {31'd0, redirect_vld}, 32'd1);
    chk({tag, "/r_pc"}, redirect_pc, target);
    chk({tag, "/r_hold"}, {30'd0, hold, flush}, 32'd3);
    chk({tag, "/r_strobes"}, {29'd0, trap_mepc_vld, trap_mcause_vld, trap_mstatus_vld}, 32'd0);
    tick();
    chk({tag, "/done_hold"}, {30'd0, hold, flush}, 32'd0);
    chk_quiet({tag, "/done"});
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; set_class(4'd0); ex_busy = 1'b0;
    irq_ext = 1'b0; irq_timer = 1'b0;
    csr_mstatus = '0; csr_mepc = '0; csr_mtvec = '0; csr_mie = '0;
    repeat (3) tick();
    chk("reset/outs", {trap_mepc_vld, trap_mcause_vld, trap_mstatus_vld, hold, flush, redirect_vld},
        32'd0);
    chk("reset/data", trap_mepc | trap_mcause | trap_mstatus | redirect_pc | irq_pending, 32'd0);
    rst = 1'b0;

    run_event("ecall",   4'b0001, 32'h100, 32'h8,    32'h0,   32'h800, 32'h0,   0, 0, 0, 0);
    run_event("mret",    4'b1000, 32'h104, 32'h1880, 32'h104, 32'h800, 32'h0,   0, 0, 0, 0);
    run_event("timer",   4'b0000, 32'h200, 32'h8,    32'h0,   32'h801, 32'h80,  0, 1, 0, 0);
    run_event("ext_lag", 4'b0001, 32'h300, 32'h8,    32'h0,   32'h801, 32'h880, 1, 1, 1, 0);
    run_event("ext",     4'b0001, 32'h300, 32'h8,    32'h0,   32'h801, 32'h880, 1, 1, 0, 0);
    run_event("mie_off", 4'b0000, 32'h400, 32'h0,    32'h0,   32'h800, 32'h80,  0, 1, 0, 0);
    run_event("ebreak_busy", 4'b0010, 32'h500, 32'h8, 32'h0,  32'h900, 32'h0,   0, 0, 0, 3);
    run_event("illegal_vec", 4'b0101, 32'h600, 32'h8, 32'h0,  32'hA01, 32'h0,   0, 0, 0, 0);
    run_event("irq_mret",    4'b1000, 32'h700, 32'h88, 32'h44, 32'hB01, 32'h80, 0, 1, 0, 1);

    // reset while waiting on a busy multicycle op
    irq_ext = 1'b0; irq_timer = 1'b0; repeat (3) tick();
    ex_valid = 1'b1; set_class(4'b0010); ex_busy = 1'b1; ex_pc = 32'h800;
    #1;
    chk("rst_wb/n_hold", {31'd0, hold}, 32'd1);
    tick();
    ex_valid = 1'b0; set_class(4'd0);
    #1;
    chk("rst_wb/wait_hold", {31'd0, hold}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_wb/outs", {trap_mepc_vld, trap_mcause_vld, trap_mstatus_vld, hold, flush, redirect_vld},
        32'd0);
    rst = 1'b0; ex_busy = 1'b0;
    repeat (3) begin
      tick();
      chk_quiet("rst_wb/after");
      chk("rst_wb/after_hold", {31'd0, hold}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      run_event("rand", 4'($urandom_range(0, 15)), $urandom & ~32'h3, $urandom, $urandom & ~32'h3,
                $urandom & ~32'h2, $urandom & 32'h880, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap/interrupt sequencer for the RV32 core. Sits between the EX stage and the CSR file.
- Detects synchronous exceptions (ecall, ebreak, illegal), mret, and timer/external interrupts.
- Drives the CSR file's one-shot mepc/mcause/mstatus update port, then stalls, flushes and redirects the pipeline to the trap vector or to mepc.

Parameters:
- VECTORED_EN, 1, honour mtvec.MODE=1 (vectored interrupts); 0 = always direct.
- IRQ_SYNC_STAGES, 2, flop stages on asynchronous irq_ext (min 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ex_valid  in  1  EX holds a valid, not-yet-committed instruction
- ex_pc  in  32  PC of EX instruction
- ex_ecall / ex_ebreak / ex_illegal / ex_mret  in  1 each  decoded EX instruction class
- ex_busy  in  1  older multicycle op still in flight; trap must wait
- irq_ext  in  1  external interrupt, asynchronous, level
- irq_timer  in  1  timer interrupt, synchronous to clk, level
- csr_mstatus / csr_mepc / csr_mtvec / csr_mie  in  32 each  current CSR values from the CSR file
- trap_mepc_vld / trap_mcause_vld / trap_mstatus_vld  out  1 each  CSR update strobes
- trap_mepc / trap_mcause / trap_mstatus  out  32 each  CSR update data
- hold  out  1  stall IF/ID/EX
- flush  out  1  kill EX instruction and younger; pipeline must gate its CSR/regfile writes
- redirect_vld  out  1  one-cycle PC redirect
- redirect_pc  out  32  redirect target
- irq_pending  out  32  mip view: bit11 = synced irq_ext, bit7 = irq_timer, others 0

Behaviour:
Reset and synchronisation:
- Synchronous reset (rst, active-high). All outputs 0 after reset; FSM in IDLE; sync chain cleared.
- irq_ext passes through IRQ_SYNC_STAGES flops before use. irq_timer is used directly.

Interrupt and event evaluation:
- int_take = csr_mstatus[3] & ex_valid & ((irq_ext_s & csr_mie[11]) | (irq_timer & csr_mie[7])).
- Priority, highest first: external (cause 0x8000000B), timer (0x80000007), illegal (2), ebreak (3), ecall (11), mret.
- Interrupts beat any exception or mret on the same instruction. That instruction is killed and re-executes after return.

FSM states: IDLE, WAIT_BUSY, COMMIT, REDIRECT.
- IDLE: an event is present (int_take, or ex_valid with a class bit set).
  - Latch kind, cause and ex_pc.
  - Assert hold=1 and flush=1 combinationally in the same cycle.
  - Next state: WAIT_BUSY if ex_busy, else COMMIT.
- WAIT_BUSY: hold=1, flush=1. Stay while ex_busy=1, then go to COMMIT. New irqs are ignored here.
- COMMIT: one-cycle strobes, then go to REDIRECT.
  - Trap: all three vld=1; trap_mepc = latched pc; trap_mcause = latched cause.
  - Trap mstatus = csr_mstatus with MPP[12:11]=2'b11, MPIE[7]=MIE[3], MIE[3]=0.
  - mret: only trap_mstatus_vld=1; mstatus with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
- REDIRECT: redirect_vld=1, hold=1, flush=1, then go to IDLE.
  - mret: redirect_pc = csr_mepc.
  - Trap, direct: redirect_pc = {mtvec[31:2],2'b00}.
  - Trap, vectored: if VECTORED_EN, mtvec[1:0]=01 and the cause is an interrupt, redirect_pc = base + 4*cause[4:0]. Otherwise direct.

Timing and boundary conditions:
- Latency with ex_busy=0: event at cycle N, COMMIT at N+1, REDIRECT at N+2, IDLE at N+3.
- hold and flush are high N..N+2. Strobes and redirect are exactly one cycle each.
- Trap strobes have priority over a same-cycle csrrw in the CSR file; flush guarantees the killed instruction never writes.
- All strobes are 0 outside COMMIT. redirect_vld is 0 outside REDIRECT.
- rst in any state returns to IDLE next edge with no strobes, even mid WAIT_BUSY or COMMIT.
- ex_valid=0 in IDLE: no event is taken, including pending interrupts.

Decomposition:
- Shared defines: cause codes, mstatus bit indices (MIE=3, MPIE=7, MPP=12:11), mie/mip bit indices (7, 11), FSM state encoding.
- Sub-module irq_sync: IRQ_SYNC_STAGES-deep synchroniser for irq_ext.

Test Plan:
1. ecall, ex_pc=0x100, mtvec=0x800, mstatus=0x8:
   - N+1: mepc=0x100, mcause=0xB, mstatus=0x1880, three strobes.
   - N+2: redirect_pc=0x800.
2. mret, csr_mepc=0x104, mstatus=0x1880 -> N+1: only trap_mstatus_vld, value 0x1888; N+2: redirect_pc=0x104.
3. irq_timer=1, mie=0x80, mstatus=0x8, mtvec=0x801, ex_pc=0x200 -> mcause=0x80000007, mepc=0x200, redirect_pc=0x81C.
4. irq_ext rises together with irq_timer, mie=0x880, and an ecall in EX:
   - Timer trap is taken first (irq_ext still synchronising).
   - Rerun with irq_ext stable for 2 cycles: mcause=0x8000000B.
5. mstatus=0x0 with irq_timer=1 and mie=0x80 -> no strobes, hold=0, irq_pending=0x80.
6. ebreak while ex_busy stays high 3 cycles:
   - hold stays 1 and the FSM stays in WAIT_BUSY.
   - COMMIT follows 1 cycle after busy drops, with mcause=3.
   - Repeat with rst asserted during WAIT_BUSY: no CSR strobe, all outputs 0.
